// File: rtl/regfile_write_sched.sv
// Write-back scheduler: queues up to three commit results per cycle in age
// order and drains them onto the register file's two write ports.
module regfile_write_sched #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid0,
  input  logic                     in_valid1,
  input  logic                     in_valid2,
  input  logic [3:0]               in_addr0,
  input  logic [3:0]               in_addr1,
  input  logic [3:0]               in_addr2,
  input  logic [15:0]              in_data0,
  input  logic [15:0]              in_data1,
  input  logic [15:0]              in_data2,
  output logic                     in_ready,
  output logic                     wen0,
  output logic [3:0]               waddr0,
  output logic [15:0]              wdata0,
  output logic                     wen1,
  output logic [3:0]               waddr1,
  output logic [15:0]              wdata1,
  output logic [15:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem_addr [DEPTH];
  logic [15:0]   mem_data [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head1;
  logic [AW-1:0] slot1;
  logic [AW-1:0] slot2;
  logic [CW-1:0] cnt_q;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;
  logic          h0_ok;
  logic          h1_ok;
  logic          same;

  assign head1 = head + AW'(1);
  assign h0_ok = cnt_q != '0;
  assign h1_ok = cnt_q >= CW'(2);
  assign same  = mem_addr[head] == mem_addr[head1];

  // Ready looks only at the registered count, ignoring this cycle's drain.
  assign in_ready = (CW'(DEPTH) - cnt_q) >= CW'(3);

  assign enq_n = in_ready ?
    ({1'b0, in_valid0} + {1'b0, in_valid1} + {1'b0, in_valid2}) : 2'd0;
  assign deq_n = h1_ok ? 2'd2 : {1'b0, h0_ok};

  // Valid lanes are packed into consecutive slots starting at the tail.
  assign slot1 = tail + AW'(in_valid0);
  assign slot2 = slot1 + AW'(in_valid1);

  assign count = cnt_q;

  always_comb begin
    wen0   = 1'b0;
    waddr0 = '0;
    wdata0 = '0;
    wen1   = 1'b0;
    waddr1 = '0;
    wdata1 = '0;
    if (h0_ok && !(h1_ok && same)) begin
      wen0   = 1'b1;
      waddr0 = mem_addr[head];
      wdata0 = mem_data[head];
    end
    if (h1_ok) begin
      wen1   = 1'b1;
      waddr1 = mem_addr[head1];
      wdata1 = mem_data[head1];
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, AW'(AW'(i) - head)} < cnt_q) begin
        pending_mask[mem_addr[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else begin
      head  <= head + AW'(deq_n);
      tail  <= tail + AW'(enq_n);
      cnt_q <= cnt_q + CW'(enq_n) - CW'(deq_n);
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && !reset) begin
      if (in_valid0) begin
        mem_addr[tail] <= in_addr0;
        mem_data[tail] <= in_data0;
      end
      if (in_valid1) begin
        mem_addr[slot1] <= in_addr1;
        mem_data[slot1] <= in_data1;
      end
      if (in_valid2) begin
        mem_addr[slot2] <= in_addr2;
        mem_data[slot2] <= in_data2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for regfile_write_sched: directed vector table followed by random
// traffic checked against a queue-based model of the scheduler.
module tb_regfile_write_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid0, in_valid1, in_valid2;
  logic [3:0]  in_addr0, in_addr1, in_addr2;
  logic [15:0] in_data0, in_data1, in_data2;
  logic        in_ready;
  logic        wen0, wen1;
  logic [3:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic [15:0] pending_mask;
  logic [3:0]  count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_write_sched #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid0(in_valid0), .in_valid1(in_valid1), .in_valid2(in_valid2),
    .in_addr0(in_addr0), .in_addr1(in_addr1), .in_addr2(in_addr2),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
    .in_ready(in_ready),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .pending_mask(pending_mask), .count(count)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [3:0]  a0, a1, a2;
    logic [15:0] d0, d1, d2;
    logic        e0;
    logic [3:0]  wa0;
    logic [15:0] wd0;
    logic        e1;
    logic [3:0]  wa1;
    logic [15:0] wd1;
    logic [15:0] mask;
    logic [3:0]  cnt;
    logic        rdy;
  } vec_t;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  vec_t vq[$];
  ent_t q[$];
  logic [15:0] ref_rf [16];
  logic [15:0] dut_rf [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [2:0] v,
                     input logic [3:0] a0, input logic [15:0] d0,
                     input logic [3:0] a1, input logic [15:0] d1,
                     input logic [3:0] a2, input logic [15:0] d2,
                     input logic e0, input logic [3:0] wa0,
                     input logic [15:0] wd0,
                     input logic e1, input logic [3:0] wa1,
                     input logic [15:0] wd1,
                     input logic [15:0] mask, input logic [3:0] cnt,
                     input logic rdy);
    vec_t t;
    t.rst = rst; t.v = v;
    t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.e0 = e0; t.wa0 = wa0; t.wd0 = wd0;
    t.e1 = e1; t.wa1 = wa1; t.wd1 = wd1;
    t.mask = mask; t.cnt = cnt; t.rdy = rdy;
    vq.push_back(t);
  endtask

  task automatic drive(input logic rst, input logic [2:0] v,
                       input logic [3:0] a0, input logic [15:0] d0,
                       input logic [3:0] a1, input logic [15:0] d1,
                       input logic [3:0] a2, input logic [15:0] d2);
    reset = rst;
    in_valid0 = v[0]; in_valid1 = v[1]; in_valid2 = v[2];
    in_addr0 = a0; in_addr1 = a1; in_addr2 = a2;
    in_data0 = d0; in_data1 = d1; in_data2 = d2;
  endtask

  task automatic check_model(input string tag);
    logic        e0, e1;
    logic [3:0]  wa0, wa1;
    logic [15:0] wd0, wd1, m;
    e0 = 0; e1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; m = 0;
    foreach (q[i]) m[q[i].a] = 1'b1;
    if (q.size() >= 2) begin
      e1 = 1; wa1 = q[1].a; wd1 = q[1].d;
    end
    if (q.size() >= 1 && !(q.size() >= 2 && q[0].a == q[1].a)) begin
      e0 = 1; wa0 = q[0].a; wd0 = q[0].d;
    end
    chk({tag, " port0"}, {wen0, waddr0, wdata0}, {e0, wa0, wd0});
    chk({tag, " port1"}, {wen1, waddr1, wdata1}, {e1, wa1, wd1});
    chk({tag, " mask"}, pending_mask, m);
    chk({tag, " count"}, count, q.size());
    chk({tag, " ready"}, in_ready, (8 - q.size()) >= 3);
  endtask

  initial begin
    drive(1, 3'b000, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // rst v a0 d0 a1 d1 a2 d2 | e0 wa0 wd0 e1 wa1 wd1 mask cnt rdy
    add(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(0, 3'b001, 5, 16'h1234, 0, 0, 0, 0,
        1, 5, 16'h1234, 0, 0, 0, 16'h0020, 1, 1);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(0, 3'b110, 0, 0, 2, 16'hAAAA, 3, 16'hBBBB,
        1, 2, 16'hAAAA, 1, 3, 16'hBBBB, 16'h000C, 2, 1);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(0, 3'b011, 7, 16'h0001, 7, 16'h0002, 0, 0,
        0, 0, 0, 1, 7, 16'h0002, 16'h0080, 2, 1);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(0, 3'b111, 1, 16'h11, 2, 16'h12, 3, 16'h13,
        1, 1, 16'h11, 1, 2, 16'h12, 16'h000E, 3, 1);
    add(0, 3'b111, 4, 16'h14, 5, 16'h15, 6, 16'h16,
        1, 3, 16'h13, 1, 4, 16'h14, 16'h0078, 4, 1);
    add(0, 3'b111, 8, 16'h18, 9, 16'h19, 10, 16'h1A,
        1, 5, 16'h15, 1, 6, 16'h16, 16'h0760, 5, 1);
    add(0, 3'b111, 11, 16'h1B, 12, 16'h1C, 13, 16'h1D,
        1, 8, 16'h18, 1, 9, 16'h19, 16'h3F00, 6, 0);
    add(0, 3'b111, 14, 16'h1E, 15, 16'h1F, 0, 16'h10,
        1, 10, 16'h1A, 1, 11, 16'h1B, 16'h3C00, 4, 1);
    add(0, 3'b111, 14, 16'h1E, 15, 16'h1F, 0, 16'h10,
        1, 12, 16'h1C, 1, 13, 16'h1D, 16'hF001, 5, 1);
    add(1, 3'b111, 1, 16'hDEAD, 2, 16'hBEEF, 3, 16'hCAFE,
        0, 0, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(0, 3'b100, 0, 0, 0, 0, 9, 16'h5555,
        1, 9, 16'h5555, 0, 0, 0, 16'h0200, 1, 1);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].v, vq[i].a0, vq[i].d0,
            vq[i].a1, vq[i].d1, vq[i].a2, vq[i].d2);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d port0", i), {wen0, waddr0, wdata0},
          {vq[i].e0, vq[i].wa0, vq[i].wd0});
      chk($sformatf("vec%0d port1", i), {wen1, waddr1, wdata1},
          {vq[i].e1, vq[i].wa1, vq[i].wd1});
      chk($sformatf("vec%0d mask", i), pending_mask, vq[i].mask);
      chk($sformatf("vec%0d count", i), count, vq[i].cnt);
      chk($sformatf("vec%0d ready", i), in_ready, vq[i].rdy);
    end

    // Random traffic against the queue model; DUT writes replayed into a
    // shadow register file and compared with the model's register file.
    drive(1, 3'b000, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    q.delete();
    for (int r = 0; r < 16; r++) begin
      ref_rf[r] = 16'h0;
      dut_rf[r] = 16'h0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        rst;
      logic [2:0]  v;
      logic [3:0]  a [3];
      logic [15:0] d [3];
      int          ndeq;
      bit          rdy;
      check_model("rand");
      rst = ($urandom_range(0, 249) == 0);
      for (int l = 0; l < 3; l++) begin
        v[l] = ($urandom_range(0, 3) != 0);
        a[l] = $urandom_range(0, 1) ? 4'($urandom_range(0, 3))
                                    : 4'($urandom_range(0, 15));
        d[l] = 16'($urandom);
      end
      drive(rst, v, a[0], d[0], a[1], d[1], a[2], d[2]);
      #1;
      if (!rst) begin
        if (wen0) dut_rf[waddr0] = wdata0;
        if (wen1) dut_rf[waddr1] = wdata1;
      end
      rdy = (8 - q.size()) >= 3;
      ndeq = (q.size() > 2) ? 2 : q.size();
      if (rst) begin
        q.delete();
      end else begin
        for (int k = 0; k < ndeq; k++) begin
          ent_t e;
          e = q.pop_front();
          ref_rf[e.a] = e.d;
        end
        if (rdy) begin
          for (int l = 0; l < 3; l++) begin
            if (v[l]) q.push_back({a[l], d[l]});
          end
        end
      end
      @(posedge clk);
      #1;
    end
    check_model("rand end");
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("regfile r%0d", r), dut_rf[r], ref_rf[r]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
